pht_update_unit: RTL
====================

Name: pht_update_unit

Overview:
Write-side partner of the per-address-history (SAg-style) branch predictor. It takes resolved conditional-branch results from the integer issue lanes and computes saturated counter updates. It queues those updates and drains them onto the predictor's banked PHT write ports without bank conflicts. It also emits branch-history repair writes on misprediction and performs the PHT initialisation sweep after reset.

Parameters:
ISSUE_WIDTH, 2, number of branch-result input lanes
ADDR_WIDTH, 32, instruction address width
INSN_SHIFT, 2, log2 of instruction byte width
HIST_BITS, 4, per-address history length
PC_IDX_BITS, 6, PC bits appended below history in the PHT index
HIST_IDX_BITS, 6, PC bits selecting a history register
CTR_WIDTH, 2, saturating counter width
BANK_BITS, 1, PHT index LSBs selecting the bank
FIFO_DEPTH, 8, update queue entries (power of two, at least 2*ISSUE_WIDTH)
IDX_W = HIST_BITS+PC_IDX_BITS (derived, 10)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
init_start  in  1  pulse; flush queue and restart the init sweep
in_valid  in  ISSUE_WIDTH  result valid per lane (lane 0 oldest)
in_cond  in  ISSUE_WIDTH  result is a conditional branch
in_addr  in  ISSUE_WIDTH*ADDR_WIDTH  branch address
in_prev_ctr  in  ISSUE_WIDTH*CTR_WIDTH  counter value read at prediction
in_prev_hist  in  ISSUE_WIDTH*HIST_BITS  history used at prediction
in_taken  in  ISSUE_WIDTH  resolved direction
in_mispred  in  ISSUE_WIDTH  direction mispredicted
in_ready  out  1  queue can accept ISSUE_WIDTH entries this cycle
pht_we  out  2  PHT write enable per port
pht_wa  out  2*IDX_W  PHT write address
pht_wv  out  2*CTR_WIDTH  PHT write value
repair_valid  out  1  history repair write
repair_idx  out  HIST_IDX_BITS  history register index
repair_hist  out  HIST_BITS  corrected history
init_busy  out  1  init sweep in progress
overflow  out  1  sticky: a result was dropped

Behaviour:
- Reset (async): all outputs 0, queue empty, sweep counter 0, state INIT entered after deassertion.
- States:
  - INIT: each cycle pht_we[0]=1, pht_wa[0]=sweep counter, pht_wv[0]=2^(CTR_WIDTH-1); pht_we[1]=0. Counter increments; after index 2^IDX_W-1 go to RUN.
  - In INIT, init_busy=1, in_ready=0, inputs ignored (no overflow flagged), repair outputs 0.
  - RUN: normal operation. init_start in any state: queue flushed, counter 0, INIT next cycle.
- Enqueue in RUN:
  - Only lanes with in_valid&in_cond are enqueued, compacted in lane order; non-conditional results are dropped silently.
  - Entry index = {prev_hist, addr[INSN_SHIFT+PC_IDX_BITS-1:INSN_SHIFT]}.
  - Entry value = taken ? min(prev_ctr+1, 2^CTR_WIDTH-1) : max(prev_ctr-1, 0).
- in_ready: registered; 1 when free entries >= ISSUE_WIDTH after this cycle's push and pop. A valid conditional lane presented while in_ready=0 is dropped and sets overflow; only rst clears overflow.
- Drain: each RUN cycle, pop the head to port 0. Pop head+1 to port 1 only if it exists and its index[BANK_BITS-1:0] differs from the head's; otherwise it waits. Order is never reordered. Outputs are registered.
- Latency: a result presented in cycle t to an empty queue is written (pht_we high) in cycle t+2.
- Push and pop in the same cycle are allowed. Queue pointers wrap mod FIFO_DEPTH.
- Repair: a lane with valid&cond&mispred in cycle t gives, in cycle t+1, repair_valid=1, repair_idx=addr[INSN_SHIFT+HIST_IDX_BITS-1:INSN_SHIFT], repair_hist={prev_hist[HIST_BITS-2:0], taken}. If several lanes qualify, the lowest lane wins. Repair is independent of queue fullness.

Test Plan:
- Deassert rst -> init_busy=1 for exactly 1024 cycles; port 0 writes wa 0..1023 with wv=2; pht_we[1]=0; in_ready=0. Then init_busy=0 and in_ready=1.
- RUN, lane0 cond taken, addr 0x104, hist 4'b1010, ctr 3 -> two cycles later pht_we=01, wa[0]=0x281, wv[0]=3. Repeat not-taken with ctr 0 -> wv[0]=0.
- Same cycle, lane0 index 0x002 (ctr 1, NT) and lane1 index 0x004 (ctr 1, T), same bank -> port0 writes 0x002/0 one cycle, then port0 writes 0x004/2 next cycle. With lane1 index 0x005 -> both ports write in one cycle.
- Both lanes mispredict: lane0 addr 0x40, hist 4'b0111, NT; lane1 another address -> next cycle repair_idx=0x10, repair_hist=4'b1110; lane1 is ignored.
- Feed two same-bank results per cycle for 6 cycles -> in_ready falls once occupancy exceeds 6. A valid lane while in_ready=0 -> overflow=1 and stays set. The queue drains in order one per cycle.
- init_start with 3 entries queued -> none of those entries are written; the sweep restarts at wa 0. Asserting rst mid-sweep -> outputs 0 immediately and the sweep restarts from 0.

Source files
------------

// File: rtl/pht_update_unit.sv
// pht_update_unit: write side of the per-address-history branch predictor.
// Turns resolved conditional branches into saturated PHT counter updates,
// queues them, drains them onto two banked PHT write ports without bank
// conflicts, emits history repair writes on mispredicts, and sweeps the
// whole PHT to weakly-taken after reset or on request.
module pht_update_unit #(
    parameter int ISSUE_WIDTH   = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int INSN_SHIFT    = 2,
    parameter int HIST_BITS     = 4,
    parameter int PC_IDX_BITS   = 6,
    parameter int HIST_IDX_BITS = 6,
    parameter int CTR_WIDTH     = 2,
    parameter int BANK_BITS     = 1,
    parameter int FIFO_DEPTH    = 8,
    localparam int IDX_W        = HIST_BITS + PC_IDX_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              init_start,
    input  logic [ISSUE_WIDTH-1:0]            in_valid,
    input  logic [ISSUE_WIDTH-1:0]            in_cond,
    input  logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] in_addr,
    input  logic [ISSUE_WIDTH*CTR_WIDTH-1:0]  in_prev_ctr,
    input  logic [ISSUE_WIDTH*HIST_BITS-1:0]  in_prev_hist,
    input  logic [ISSUE_WIDTH-1:0]            in_taken,
    input  logic [ISSUE_WIDTH-1:0]            in_mispred,
    output logic                              in_ready,
    output logic [1:0]                        pht_we,
    output logic [2*IDX_W-1:0]                pht_wa,
    output logic [2*CTR_WIDTH-1:0]            pht_wv,
    output logic                              repair_valid,
    output logic [HIST_IDX_BITS-1:0]          repair_idx,
    output logic [HIST_BITS-1:0]              repair_hist,
    output logic                              init_busy,
    output logic                              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
    localparam logic [CNT_W-1:0] READY_LIMIT  = CNT_W'(FIFO_DEPTH - ISSUE_WIDTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state;
    logic [IDX_W-1:0] sweep;

    // Update queue storage and pointers
    logic [IDX_W-1:0]     q_idx [FIFO_DEPTH];
    logic [CTR_WIDTH-1:0] q_val [FIFO_DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    // Per-lane decoded fields
    logic [HIST_BITS-1:0]     lane_hist [ISSUE_WIDTH];
    logic [CTR_WIDTH-1:0]     lane_ctr  [ISSUE_WIDTH];
    logic [IDX_W-1:0]         lane_idx  [ISSUE_WIDTH];
    logic [CTR_WIDTH-1:0]     lane_val  [ISSUE_WIDTH];
    logic [HIST_IDX_BITS-1:0] lane_ridx [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]   lane_push;
    logic [PTR_W-1:0]         slot      [ISSUE_WIDTH];
    logic [CNT_W-1:0]         push_cnt;
    logic                     drop_any;

    // Drain selection
    logic [PTR_W-1:0]     head_p1;
    logic                 pop0;
    logic                 pop1;
    logic [CNT_W-1:0]     pop_cnt;
    logic [CNT_W-1:0]     count_next;
    logic                 ready_next;
    logic [IDX_W-1:0]     wa0_next;
    logic [IDX_W-1:0]     wa1_next;
    logic [CTR_WIDTH-1:0] wv0_next;
    logic [CTR_WIDTH-1:0] wv1_next;

    // Repair selection
    logic                     rep_any;
    logic [HIST_IDX_BITS-1:0] rep_idx;
    logic [HIST_BITS-1:0]     rep_hist;

    // Only a few address bits form indices; the rest are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^in_addr;

    // Decode each lane into its PHT index and saturated counter update, and
    // compact the conditional lanes into consecutive queue slots in lane order.
    always_comb begin
        push_cnt = '0;
        drop_any = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            lane_hist[i] = in_prev_hist[i*HIST_BITS +: HIST_BITS];
            lane_ctr[i]  = in_prev_ctr[i*CTR_WIDTH +: CTR_WIDTH];
            lane_idx[i]  = {lane_hist[i], in_addr[i*ADDR_WIDTH + INSN_SHIFT +: PC_IDX_BITS]};
            lane_ridx[i] = in_addr[i*ADDR_WIDTH + INSN_SHIFT +: HIST_IDX_BITS];
            if (in_taken[i]) begin
                lane_val[i] = (lane_ctr[i] == CTR_MAX) ? CTR_MAX : lane_ctr[i] + CTR_WIDTH'(1);
            end else begin
                lane_val[i] = (lane_ctr[i] == '0) ? '0 : lane_ctr[i] - CTR_WIDTH'(1);
            end
            lane_push[i] = in_valid[i] & in_cond[i] & (state == ST_RUN) & in_ready & ~init_start;
            if (in_valid[i] && in_cond[i] && (state == ST_RUN) && !in_ready && !init_start) begin
                drop_any = 1'b1;
            end
            slot[i] = tail + push_cnt[PTR_W-1:0];
            if (lane_push[i]) begin
                push_cnt = push_cnt + CNT_W'(1);
            end
        end
    end

    // Pop the head every RUN cycle; the next entry rides along on port 1
    // only when it targets the other bank, so write order is preserved.
    always_comb begin
        head_p1    = head + PTR_W'(1);
        pop0       = (state == ST_RUN) && (count != '0);
        pop1       = pop0 && (count >= CNT_W'(2)) &&
                     (q_idx[head][BANK_BITS-1:0] != q_idx[head_p1][BANK_BITS-1:0]);
        pop_cnt    = CNT_W'(pop0) + CNT_W'(pop1);
        count_next = count + push_cnt - pop_cnt;
        ready_next = (count_next <= READY_LIMIT);
        wa0_next   = pop0 ? q_idx[head]    : '0;
        wv0_next   = pop0 ? q_val[head]    : '0;
        wa1_next   = pop1 ? q_idx[head_p1] : '0;
        wv1_next   = pop1 ? q_val[head_p1] : '0;
    end

    // Pick the lowest mispredicting conditional lane for the history repair.
    always_comb begin
        rep_any  = 1'b0;
        rep_idx  = '0;
        rep_hist = '0;
        for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
            if (in_valid[i] && in_cond[i] && in_mispred[i] && (state == ST_RUN)) begin
                rep_any  = 1'b1;
                rep_idx  = lane_ridx[i];
                rep_hist = {lane_hist[i][HIST_BITS-2:0], in_taken[i]};
            end
        end
    end

    // Queue payload storage; occupancy is tracked separately so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (lane_push[i]) begin
                q_idx[slot[i]] <= lane_idx[i];
                q_val[slot[i]] <= lane_val[i];
            end
        end
    end

    // Control FSM: init sweep, queue pointers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_INIT;
            sweep        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            in_ready     <= 1'b0;
            pht_we       <= '0;
            pht_wa       <= '0;
            pht_wv       <= '0;
            repair_valid <= 1'b0;
            repair_idx   <= '0;
            repair_hist  <= '0;
            init_busy    <= 1'b0;
            overflow     <= 1'b0;
        end else if (init_start) begin
            state        <= ST_INIT;
            sweep        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            in_ready     <= 1'b0;
            pht_we       <= '0;
            pht_wa       <= '0;
            pht_wv       <= '0;
            repair_valid <= 1'b0;
            repair_idx   <= '0;
            repair_hist  <= '0;
            init_busy    <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    pht_we       <= 2'b01;
                    pht_wa       <= {{IDX_W{1'b0}}, sweep};
                    pht_wv       <= {{CTR_WIDTH{1'b0}}, CTR_INIT};
                    repair_valid <= 1'b0;
                    repair_idx   <= '0;
                    repair_hist  <= '0;
                    init_busy    <= 1'b1;
                    in_ready     <= 1'b0;
                    sweep        <= sweep + IDX_W'(1);
                    if (sweep == {IDX_W{1'b1}}) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    init_busy    <= 1'b0;
                    head         <= head + pop_cnt[PTR_W-1:0];
                    tail         <= tail + push_cnt[PTR_W-1:0];
                    count        <= count_next;
                    in_ready     <= ready_next;
                    pht_we       <= {pop1, pop0};
                    pht_wa       <= {wa1_next, wa0_next};
                    pht_wv       <= {wv1_next, wv0_next};
                    repair_valid <= rep_any;
                    repair_idx   <= rep_idx;
                    repair_hist  <= rep_hist;
                    if (drop_any) begin
                        overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
